// File: rtl/multi_tick_generator_pkg.sv
// Shared constants and helpers for multi_tick_generator and its channels.
// Divisor and counter widths up to 32 bits are supported by the helpers.
package tick_gen_pkg;

   localparam int unsigned DIV_MIN = 2;

   // Source selected for the next div_q value of a channel
   typedef enum logic [1:0] {
      LOAD_NONE,
      LOAD_PEND,
      LOAD_WR
   } div_load_e;

   function automatic logic [31:0] clamp_div(input logic [31:0] val);
      return (val < DIV_MIN) ? DIV_MIN : val;
   endfunction

   function automatic logic [31:0] half_up(input logic [31:0] d);
      return (d >> 1) + {31'b0, d[0]};
   endfunction

   function automatic int unsigned ch_idx_w(input int unsigned n);
      return (n > 1) ? int'($clog2(n)) : 1;
   endfunction

endpackage

// File: rtl/multi_tick_generator_if.sv
// Divisor write bus of multi_tick_generator: strobe, channel, value and
// per-channel pending flags returned by the generator.
interface multi_tick_generator_if
   import tick_gen_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned DIV_W  = 27
) ();

   localparam int unsigned CH_W = ch_idx_w(NUM_CH);

   logic              div_wr_en;
   logic [CH_W-1:0]   div_wr_ch;
   logic [DIV_W-1:0]  div_wr_val;
   logic [NUM_CH-1:0] div_pending;

   modport master (
      output div_wr_en,
      output div_wr_ch,
      output div_wr_val,
      input  div_pending
   );

   modport slave (
      input  div_wr_en,
      input  div_wr_ch,
      input  div_wr_val,
      output div_pending
   );

endinterface

// File: rtl/multi_tick_generator_channel.sv
// One tick channel: period counter, active/pending divisor and registered
// pulse, square and pending outputs.
module tick_channel
   import tick_gen_pkg::*;
#(
   parameter int unsigned DIV_W       = 27,
   parameter int unsigned DEFAULT_DIV = 500_000
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_val,
   output logic             pending,
   output logic             tick,
   output logic             sq
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] pend_q;
   logic [DIV_W-1:0] wr_div;
   logic [DIV_W-1:0] half;
   logic             wrap;
   div_load_e        load_sel;

   assign wr_div = DIV_W'(clamp_div(32'(wr_val)));
   assign half   = DIV_W'(half_up(32'(div_q)));
   assign wrap   = (cnt == div_q - DIV_W'(1));

   // A write landing on the wrap cycle replaces the pending value instead of
   // being applied, so the new divisor waits for the following wrap.
   always_comb begin
      load_sel = LOAD_NONE;
      if (en) begin
         if (pending && (sync || (wrap && !wr)))
            load_sel = LOAD_PEND;
      end else if (wr) begin
         load_sel = LOAD_WR;
      end else if (pending) begin
         load_sel = LOAD_PEND;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         cnt     <= '0;
         div_q   <= DIV_W'(clamp_div(DEFAULT_DIV));
         pend_q  <= '0;
         pending <= 1'b0;
         tick    <= 1'b0;
         sq      <= 1'b0;
      end else begin
         case (load_sel)
            LOAD_PEND: div_q <= pend_q;
            LOAD_WR:   div_q <= wr_div;
            default:   ;
         endcase

         if (en && wr) begin
            pend_q  <= wr_div;
            pending <= 1'b1;
         end else if (load_sel != LOAD_NONE) begin
            pending <= 1'b0;
         end

         if (!en || sync) begin
            cnt  <= '0;
            tick <= 1'b0;
            sq   <= 1'b0;
         end else begin
            cnt  <= wrap ? '0 : cnt + DIV_W'(1);
            tick <= wrap;
            sq   <= (cnt >= half);
         end
      end
   end

endmodule

// File: rtl/multi_tick_generator.sv
// N-channel programmable tick generator: write-address decode and channel array.
// Define TICK_GEN_SYNC_START_EN to add the sync_start phase-alignment input.
module multi_tick_generator
   import tick_gen_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned DIV_W       = 27,
   parameter int unsigned DEFAULT_DIV = 500_000
) (
   input  logic                    clk_in,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       ch_en,
   multi_tick_generator_if.slave   wr_bus,
`ifdef TICK_GEN_SYNC_START_EN
   input  logic                    sync_start,
`endif
   output logic [NUM_CH-1:0]       tick_out,
   output logic [NUM_CH-1:0]       sq_out
);

   localparam int unsigned CH_W = ch_idx_w(NUM_CH);

   logic              sync_all;
   logic [NUM_CH-1:0] wr_hit;
   logic [NUM_CH-1:0] pend_vec;

`ifdef TICK_GEN_SYNC_START_EN
   assign sync_all = sync_start;
`else
   assign sync_all = 1'b0;
`endif

   assign wr_bus.div_pending = pend_vec;

   // Indices at or above NUM_CH match no channel and are dropped here
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign wr_hit[i] = wr_bus.div_wr_en && (wr_bus.div_wr_ch == CH_W'(i));

      tick_channel #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_in  (clk_in),
         .rst     (rst),
         .en      (ch_en[i]),
         .sync    (sync_all),
         .wr      (wr_hit[i]),
         .wr_val  (wr_bus.div_wr_val),
         .pending (pend_vec[i]),
         .tick    (tick_out[i]),
         .sq      (sq_out[i])
      );
   end

endmodule
